hs32_wb_bridge: RTL and testbench

- Wishbone classic responder that lets the management SoC (Wishbone initiator) reach the hs32 internal memory bus, serving the wbs_* ports of the core wrapper.
- Acts as initiator on the hs32 stb/ack bus, in parallel with the CPU, through a simple req/gnt arbiter.
- The hs32 bus has no byte mask, so partial-byte writes are performed as read-modify-write.
- Optional timeout returns an error word if the hs32 bus never acks.

---
 rtl/hs32_wb_bridge.sv | 172 +++++++++++++++++
 tb/tb_hs32_wb_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_wb_bridge.sv
// Wishbone classic responder giving the management SoC access to the hs32 memory bus.
// Define HS32_WB_TIMEOUT_EN to add an hs32 ack timeout with a sticky o_err flag.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a Wishbone strobe; misses are answered from here
// ARB      | o_req raised, waiting for i_gnt
// RD       | hs32 read outstanding
// WR       | hs32 full-word write outstanding
// RMW_RD   | read half of a partial-byte write
// RMW_WR   | write-back of the merged word
// RESP     | one-cycle Wishbone ack
module hs32_wb_bridge #(
  parameter logic [31:0] BASE    = 32'h3000_0000,
  parameter int unsigned AW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        o_req,
  input  logic        i_gnt,
  output logic        o_stb,
  output logic        o_rw,
  output logic [31:0] o_addr,
  output logic [31:0] o_dwrite,
  input  logic        i_ack,
  input  logic [31:0] i_dread,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_RD, S_WR, S_RMW_RD, S_RMW_WR, S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] adr_q;
  logic [31:0]   dat_q, merged_q, merged;
  logic [3:0]    sel_q;
  logic          we_q;
  logic          stb_q, stb_d, abort_q;
  logic          in_win, hit, miss, busy, aborted, tmo;
  logic          cap_req, cap_rd, cap_merge, clr_dat;

  assign in_win  = (wbs_adr_i[31:AW] == BASE[31:AW]);
  assign hit     = wbs_cyc_i & wbs_stb_i & in_win;
  assign miss    = wbs_cyc_i & wbs_stb_i & ~in_win;
  assign busy    = state_q inside {S_RD, S_WR, S_RMW_RD, S_RMW_WR};
  // Once the initiator drops cyc the transfer is abandoned, but any hs32 access still completes.
  assign aborted = abort_q | ~wbs_cyc_i;

  always_comb begin
    merged = i_dread;
    for (int b = 0; b < 4; b++)
      if (sel_q[b]) merged[8*b +: 8] = dat_q[8*b +: 8];
  end

`ifdef HS32_WB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        err_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (stb_d)     tmo_cnt <= '0;
      else if (busy) tmo_cnt <= tmo_cnt + 16'd1;
      if (tmo)       err_q   <= 1'b1;
    end
  end

  assign tmo   = busy & ~i_ack & (tmo_cnt == 16'(TIMEOUT - 1));
  assign o_err = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign tmo   = 1'b0;
  assign o_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cap_req   = 1'b0;
    cap_rd    = 1'b0;
    cap_merge = 1'b0;
    clr_dat   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          cap_req = 1'b1;
          state_d = S_ARB;
        end else if (miss) begin
          clr_dat = 1'b1;
          state_d = S_RESP;
        end
      end
      S_ARB: begin
        if (!wbs_cyc_i)              state_d = S_IDLE;
        else if (i_gnt) begin
          if (!we_q)                 state_d = S_RD;
          else if (sel_q == 4'b1111) state_d = S_WR;
          else if (sel_q == 4'b0000) state_d = S_RESP;
          else                       state_d = S_RMW_RD;
        end
      end
      S_RD: begin
        if (tmo)        state_d = aborted ? S_IDLE : S_RESP;
        else if (i_ack) begin
          cap_rd  = 1'b1;
          state_d = aborted ? S_IDLE : S_RESP;
        end
      end
      S_RMW_RD: begin
        if (tmo)        state_d = aborted ? S_IDLE : S_RESP;
        else if (i_ack) begin
          cap_merge = 1'b1;
          state_d   = S_RMW_WR;
        end
      end
      S_WR, S_RMW_WR: begin
        if (tmo || i_ack) state_d = aborted ? S_IDLE : S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    stb_d = (state_d != state_q) && (state_d inside {S_RD, S_WR, S_RMW_RD, S_RMW_WR});
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      stb_q     <= 1'b0;
      abort_q   <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      merged_q  <= '0;
      wbs_dat_o <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      abort_q <= (state_q == S_IDLE) ? 1'b0 : aborted;
      if (cap_req) begin
        adr_q <= wbs_adr_i[AW-1:0];
        dat_q <= wbs_dat_i;
        sel_q <= wbs_sel_i;
        we_q  <= wbs_we_i;
      end
      if (cap_merge) merged_q <= merged;
      if (tmo)          wbs_dat_o <= 32'hDEAD_BEEF;
      else if (cap_rd)  wbs_dat_o <= i_dread;
      else if (clr_dat) wbs_dat_o <= '0;
    end
  end

  assign wbs_ack_o = (state_q == S_RESP);
  assign o_req     = (state_q == S_ARB) | busy;
  assign o_stb     = stb_q;
  assign o_rw      = state_q inside {S_WR, S_RMW_WR};
  assign o_addr    = {{(32-AW){1'b0}}, adr_q};
  assign o_dwrite  = (state_q == S_RMW_WR) ? merged_q : dat_q;

endmodule

// File: tb/tb_hs32_wb_bridge.sv
// Directed bench for hs32_wb_bridge: a one-word hs32 memory responder with programmable
// ack latency, an o_stb logger, and hand-computed expectations.
module tb_hs32_wb_bridge;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        o_req, i_gnt, o_stb, o_rw;
  logic [31:0] o_addr, o_dwrite;
  logic        i_ack;
  logic [31:0] i_dread;
  logic        o_err;

  always #5 i_clk = ~i_clk;

  hs32_wb_bridge #(.BASE(BASE), .AW(16), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .o_req(o_req), .i_gnt(i_gnt), .o_stb(o_stb), .o_rw(o_rw),
    .o_addr(o_addr), .o_dwrite(o_dwrite), .i_ack(i_ack), .i_dread(i_dread),
    .o_err(o_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // o_stb logger and ack counter
  int          stb_cnt = 0;
  int          ack_cnt = 0;
  logic        log_rw   [64];
  logic [31:0] log_addr [64];
  logic [31:0] log_dw   [64];

  always @(negedge i_clk) begin
    if (o_stb) begin
      log_rw[stb_cnt % 64]   <= o_rw;
      log_addr[stb_cnt % 64] <= o_addr;
      log_dw[stb_cnt % 64]   <= o_dwrite;
      stb_cnt <= stb_cnt + 1;
    end
    if (wbs_ack_o) ack_cnt <= ack_cnt + 1;
  end

  logic [31:0] mem;
  int          ack_lat;
  bit          ack_en;
  logic        rsp_rw;
  logic [31:0] rsp_dw;

  logic [31:0] rdat;
  int          cyc_n, s0, a0;
  bit          got, rdrop, rseen, seen;

  task automatic wb_start(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_sel_i = sel;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
  endtask

  task automatic wb_wait(output logic [31:0] rd, output int n, output bit g,
                         output bit drop, output bit req_seen);
    bit seen_stb = 0;
    g = 0; drop = 0; req_seen = 0; n = 0; rd = '0;
    for (int k = 1; k <= 100 && !g; k++) begin
      @(negedge i_clk);
      if (o_req) req_seen = 1;
      if (o_stb) seen_stb = 1;
      if (seen_stb && !o_req && !wbs_ack_o) drop = 1;
      if (wbs_ack_o) begin
        g  = 1;
        n  = k;
        rd = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    @(negedge i_clk);
    chk("no_double_ack", wbs_ack_o, 1'b0);
  endtask

  initial begin
    i_reset = 1'b1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0;
    i_gnt = 1'b1; i_ack = 1'b0; i_dread = '0;
    mem = '0; ack_lat = 2; ack_en = 1;

    fork
      forever begin
        @(negedge i_clk);
        if (o_stb && ack_en) begin
          rsp_rw = o_rw;
          rsp_dw = o_dwrite;
          repeat (ack_lat) @(posedge i_clk);
          #1;
          if (rsp_rw) mem = rsp_dw;
          i_dread = rsp_rw ? 32'h0 : mem;
          i_ack = 1'b1;
          @(posedge i_clk);
          #1;
          i_ack = 1'b0;
          i_dread = '0;
        end
      end
    join_none

    repeat (3) @(negedge i_clk);
    chk("rst_ack", wbs_ack_o, 0);
    chk("rst_req", o_req, 0);
    chk("rst_stb", o_stb, 0);
    chk("rst_rw", o_rw, 0);
    chk("rst_err", o_err, 0);
    chk("rst_dat", wbs_dat_o, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_dwrite", o_dwrite, 0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // full-word write
    s0 = stb_cnt;
    wb_start(1, 4'hF, BASE + 32'h10, 32'h1234_5678);
    wb_wait(rdat, cyc_n, got, rdrop, rseen);
    chk("wr_ack", got, 1);
    chk("wr_stbs", stb_cnt - s0, 1);
    chk("wr_rw", log_rw[s0 % 64], 1);
    chk("wr_addr", log_addr[s0 % 64], 32'h10);
    chk("wr_dw", log_dw[s0 % 64], 32'h1234_5678);
    chk("wr_mem", mem, 32'h1234_5678);
    chk("wr_cycles", cyc_n, 5);

    // full-word read
    mem = 32'hCAFE_F00D;
    s0 = stb_cnt;
    wb_start(0, 4'hF, BASE + 32'h10, 32'h0);
    wb_wait(rdat, cyc_n, got, rdrop, rseen);
    chk("rd_ack", got, 1);
    chk("rd_data", rdat, 32'hCAFE_F00D);
    chk("rd_stbs", stb_cnt - s0, 1);
    chk("rd_rw", log_rw[s0 % 64], 0);
    chk("rd_cycles", cyc_n, 5);

    // partial write -> read-modify-write
    mem = 32'h1122_3344;
    s0 = stb_cnt;
    wb_start(1, 4'b0010, BASE + 32'h10, 32'h0000_AB00);
    wb_wait(rdat, cyc_n, got, rdrop, rseen);
    chk("rmw_ack", got, 1);
    chk("rmw_stbs", stb_cnt - s0, 2);
    chk("rmw_rw0", log_rw[s0 % 64], 0);
    chk("rmw_rw1", log_rw[(s0 + 1) % 64], 1);
    chk("rmw_dw", log_dw[(s0 + 1) % 64], 32'h1122_AB44);
    chk("rmw_req_held", rdrop, 0);
    chk("rmw_mem", mem, 32'h1122_AB44);
    chk("rmw_cycles", cyc_n, 8);

    // miss just past the window
    s0 = stb_cnt;
    wb_start(0, 4'hF, BASE + 32'h0001_0000, 32'h0);
    wb_wait(rdat, cyc_n, got, rdrop, rseen);
    chk("miss_ack", got, 1);
    chk("miss_data", rdat, 0);
    chk("miss_cycles", cyc_n, 1);
    chk("miss_req", rseen, 0);
    chk("miss_stbs", stb_cnt - s0, 0);

    // grant withheld for 10 cycles
    i_gnt = 1'b0;
    mem = 32'hA5A5_0F0F;
    s0 = stb_cnt;
    a0 = ack_cnt;
    wb_start(0, 4'hF, BASE + 32'h20, 32'h0);
    repeat (10) @(negedge i_clk);
    chk("gnt_wait_stbs", stb_cnt - s0, 0);
    chk("gnt_wait_acks", ack_cnt - a0, 0);
    chk("gnt_wait_req", o_req, 1);
    i_gnt = 1'b1;
    wb_wait(rdat, cyc_n, got, rdrop, rseen);
    chk("gnt_ack", got, 1);
    chk("gnt_data", rdat, 32'hA5A5_0F0F);
    chk("gnt_addr", log_addr[s0 % 64], 32'h20);
    chk("gnt_cycles", cyc_n, 4);

    // write with no byte lanes: ack without bus access
    s0 = stb_cnt;
    wb_start(1, 4'b0000, BASE + 32'h10, 32'hFFFF_FFFF);
    wb_wait(rdat, cyc_n, got, rdrop, rseen);
    chk("sel0_ack", got, 1);
    chk("sel0_stbs", stb_cnt - s0, 0);
    chk("sel0_cycles", cyc_n, 2);
    chk("sel0_mem", mem, 32'hA5A5_0F0F);

    // cyc dropped while the read is outstanding
    ack_lat = 3;
    s0 = stb_cnt;
    a0 = ack_cnt;
    wb_start(0, 4'hF, BASE + 32'h30, 32'h0);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge i_clk);
      seen = o_stb;
    end
    chk("abort_stb_seen", seen, 1);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    repeat (8) @(negedge i_clk);
    chk("abort_acks", ack_cnt - a0, 0);
    chk("abort_req", o_req, 0);
    chk("abort_stbs", stb_cnt - s0, 1);
    ack_lat = 2;
    mem = 32'h0000_0005;
    wb_start(0, 4'hF, BASE + 32'h10, 32'h0);
    wb_wait(rdat, cyc_n, got, rdrop, rseen);
    chk("post_abort_ack", got, 1);
    chk("post_abort_data", rdat, 32'h0000_0005);

`ifdef HS32_WB_TIMEOUT_EN
    ack_en = 0;
    wb_start(0, 4'hF, BASE + 32'h40, 32'h0);
    wb_wait(rdat, cyc_n, got, rdrop, rseen);
    chk("tmo_ack", got, 1);
    chk("tmo_data", rdat, 32'hDEAD_BEEF);
    chk("tmo_cycles", cyc_n, 10);
    chk("tmo_err", o_err, 1);
    ack_en = 1;
`endif

    // asynchronous reset in the middle of an access
    ack_en = 0;
    wb_start(0, 4'hF, BASE + 32'h10, 32'h0);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge i_clk);
      seen = o_stb;
    end
    chk("mid_rst_stb_seen", seen, 1);
    i_reset = 1'b1;
    #1;
    chk("mid_rst_req", o_req, 0);
    chk("mid_rst_stb", o_stb, 0);
    chk("mid_rst_addr", o_addr, 0);
    chk("mid_rst_dat", wbs_dat_o, 0);
    chk("mid_rst_err", o_err, 0);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b0;
    ack_en = 1;
    repeat (2) @(negedge i_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
